// File: rtl/gate_exerciser.sv
// Stimulus/checker wrapped around a combinational N_IN-input AND gate: sweeps every
// input vector, samples dut_y after a settle time and records per-vector mismatches.
// Optional build macro: GATE_EXERCISER_STOP_ON_FAIL_EN (end the sweep on the first mismatch).
module gate_exerciser #(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_IN-1:0]        stim,
  input  logic                   dut_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   fail_mask,
  output logic [N_IN:0]          fail_count
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N_IN-1:0]        stim_q, stim_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [(1<<N_IN)-1:0]   mask_q, mask_d;
  logic [N_IN:0]          count_q, count_d;
  logic                   mismatch;

  // Case inequality so an X/Z gate output is recorded as a failure.
  assign mismatch = (dut_y !== (&stim_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mask_d  = mask_q;
    count_d = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = '0;
          count_d = '0;
          stim_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          mask_d[stim_q] = 1'b1;
          count_d        = count_q + 1'b1;
        end
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
        if (mismatch || (&stim_q)) begin
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
`else
        if (&stim_q) begin
          state_d = S_DONE;
        end else begin
          stim_d  = stim_q + 1'b1;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
`endif
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (count_q == '0);
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
        // Failing vector stays on stim for readout; a clean sweep parks at 0.
        if (count_q == '0) stim_d = '0;
`else
        stim_d  = '0;
`endif
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_mask  = mask_q;
  assign fail_count = count_q;

endmodule
